// File: rtl/pipeline_stall_controller.sv
// Prioritised stall/flush sequencer for the 5-stage pipeline: merges hazard, branch and
// SRAM-wait conditions, guards memory waits with a timeout FSM, and keeps stall counters.
module pipeline_stall_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_detected,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             sram_ready,
    input  logic             clr_counters,
    output logic             freeze_pc,
    output logic             freeze_if_id,
    output logic             bubble_id_ex,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             freeze_back,
    output logic             timeout_err,
    output logic [CNT_W-1:0] hazard_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] mem_wait_cycles
);
    localparam int WC_W = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

    state_t          state;
    logic [WC_W-1:0] wait_cnt;
    logic            mem_busy;
    logic [2:0]      cnt_inc;
    logic [CNT_W-1:0] cnt [3];

    assign mem_busy = mem_req & ~sram_ready;

    // Controls are gated by rst so they read 0 the moment reset is asserted.
    always_comb begin
        freeze_pc    = 1'b0;
        freeze_if_id = 1'b0;
        bubble_id_ex = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        freeze_back  = 1'b0;
        timeout_err  = 1'b0;
        if (!rst) begin
            if (state == ERROR) begin
                freeze_pc    = 1'b1;
                freeze_if_id = 1'b1;
                freeze_back  = 1'b1;
                timeout_err  = 1'b1;
            end else if (mem_busy) begin
                freeze_pc    = 1'b1;
                freeze_if_id = 1'b1;
                freeze_back  = 1'b1;
            end else if (branch_taken) begin
                flush_if_id  = 1'b1;
                flush_id_ex  = 1'b1;
            end else if (hazard_detected) begin
                freeze_pc    = 1'b1;
                freeze_if_id = 1'b1;
                bubble_id_ex = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_busy) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WC_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (!mem_busy) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WC_LAST) begin
                        state    <= ERROR;
                    end else begin
                        wait_cnt <= wait_cnt + WC_W'(1);
                    end
                end
                default: state <= ERROR;
            endcase
        end
    end

    // Counters sample this cycle's controls; they hold once the FSM is in ERROR.
    assign cnt_inc = {mem_busy & (state != ERROR), flush_if_id, bubble_id_ex};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt[gi] <= '0;
                end else if (clr_counters) begin
                    cnt[gi] <= '0;
                end else if (cnt_inc[gi] && (state != ERROR) && (cnt[gi] != {CNT_W{1'b1}})) begin
                    cnt[gi] <= cnt[gi] + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign hazard_cycles   = cnt[0];
    assign flush_count     = cnt[1];
    assign mem_wait_cycles = cnt[2];
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller: expected control vectors are queued as
// stimulus is applied and compared once the combinational controls settle.
module tb_pipeline_stall_controller;
    logic clk = 1'b0;
    logic rst;
    logic hazard_detected, branch_taken, mem_req, sram_ready, clr_counters;

    logic freeze_pc, freeze_if_id, bubble_id_ex, flush_if_id, flush_id_ex, freeze_back, timeout_err;
    logic [15:0] hazard_cycles, flush_count, mem_wait_cycles;

    logic s_freeze_pc, s_freeze_if_id, s_bubble_id_ex, s_flush_if_id, s_flush_id_ex, s_freeze_back, s_timeout_err;
    logic [3:0] s_hazard_cycles, s_flush_count, s_mem_wait_cycles;

    logic [6:0] ctrl;
    logic [6:0] exp_q [$];
    int evaluated = 0;
    int failures  = 0;

    // {freeze_pc, freeze_if_id, bubble_id_ex, flush_if_id, flush_id_ex, freeze_back, timeout_err}
    localparam logic [6:0] NONE = 7'b0000000;
    localparam logic [6:0] HZ   = 7'b1110000;
    localparam logic [6:0] BR   = 7'b0001100;
    localparam logic [6:0] MEMB = 7'b1100010;
    localparam logic [6:0] ERR  = 7'b1100011;

    assign ctrl = {freeze_pc, freeze_if_id, bubble_id_ex, flush_if_id, flush_id_ex, freeze_back, timeout_err};

    always #5 clk = ~clk;

    pipeline_stall_controller #(.MEM_TIMEOUT(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .hazard_detected(hazard_detected), .branch_taken(branch_taken),
        .mem_req(mem_req), .sram_ready(sram_ready), .clr_counters(clr_counters),
        .freeze_pc(freeze_pc), .freeze_if_id(freeze_if_id), .bubble_id_ex(bubble_id_ex),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .freeze_back(freeze_back),
        .timeout_err(timeout_err), .hazard_cycles(hazard_cycles), .flush_count(flush_count),
        .mem_wait_cycles(mem_wait_cycles)
    );

    pipeline_stall_controller #(.MEM_TIMEOUT(16), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .hazard_detected(hazard_detected), .branch_taken(branch_taken),
        .mem_req(mem_req), .sram_ready(sram_ready), .clr_counters(clr_counters),
        .freeze_pc(s_freeze_pc), .freeze_if_id(s_freeze_if_id), .bubble_id_ex(s_bubble_id_ex),
        .flush_if_id(s_flush_if_id), .flush_id_ex(s_flush_id_ex), .freeze_back(s_freeze_back),
        .timeout_err(s_timeout_err), .hazard_cycles(s_hazard_cycles), .flush_count(s_flush_count),
        .mem_wait_cycles(s_mem_wait_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        evaluated++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        logic [6:0] e;
        e = exp_q.pop_front();
        evaluated++;
        assert (ctrl === e) else begin
            failures++;
            $error("FAIL %s ctrl observed=%b expected=%b", tag, ctrl, e);
        end
        $display("%0t %s hz=%b br=%b mr=%b sr=%b clr=%b rst=%b ctrl=%b", $time, tag,
                 hazard_detected, branch_taken, mem_req, sram_ready, clr_counters, rst, ctrl);
    endtask

    // Called at posedge+1; drives one cycle of inputs, checks controls, advances past the edge.
    task automatic cycle(input string tag, input logic hz, input logic br, input logic mr,
                         input logic sr, input logic clr, input logic [6:0] exp);
        hazard_detected = hz;
        branch_taken    = br;
        mem_req         = mr;
        sram_ready      = sr;
        clr_counters    = clr;
        exp_q.push_back(exp);
        #1;
        pop_check(tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        hazard_detected = 1'b0; branch_taken = 1'b0; mem_req = 1'b0;
        sram_ready = 1'b0; clr_counters = 1'b0;
        @(posedge clk);
        #1;
        exp_q.push_back(NONE);
        #1;
        pop_check("reset");
        chk("reset_hazard_cycles", 32'(hazard_cycles), 0);
        chk("reset_flush_count", 32'(flush_count), 0);
        chk("reset_mem_wait", 32'(mem_wait_cycles), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Two hazard cycles produce bubbles
        repeat (2) cycle("hazard", 1, 0, 0, 0, 0, HZ);
        chk("hazard_cycles_2", 32'(hazard_cycles), 2);
        cycle("idle", 0, 0, 0, 0, 0, NONE);

        // Branch beats hazard
        cycle("branch_hazard", 1, 1, 0, 0, 0, BR);
        chk("flush_count_1", 32'(flush_count), 1);
        chk("hazard_unchanged", 32'(hazard_cycles), 2);

        // Memory wait beats branch; branch flushes once SRAM answers
        repeat (4) cycle("mem_wait_br", 0, 1, 1, 0, 0, MEMB);
        cycle("mem_ready_br", 0, 1, 1, 1, 0, BR);
        chk("mem_wait_4", 32'(mem_wait_cycles), 4);
        chk("flush_count_2", 32'(flush_count), 2);
        cycle("after_mem", 0, 0, 0, 0, 0, NONE);

        // Asynchronous reset in the middle of a memory wait
        repeat (5) cycle("mem_wait_pre_rst", 0, 0, 1, 0, 0, MEMB);
        rst = 1'b1;
        exp_q.push_back(NONE);
        #1;
        pop_check("async_rst");
        chk("rst_hazard_cycles", 32'(hazard_cycles), 0);
        chk("rst_flush_count", 32'(flush_count), 0);
        chk("rst_mem_wait", 32'(mem_wait_cycles), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle("post_rst_idle", 0, 0, 0, 0, 0, NONE);

        // Ready arrives on the 16th cycle: no timeout
        repeat (15) cycle("busy15", 0, 0, 1, 0, 0, MEMB);
        cycle("ready_on_16th", 0, 0, 1, 1, 0, NONE);
        cycle("back_in_run", 1, 0, 0, 0, 0, HZ);
        chk("mem_wait_15", 32'(mem_wait_cycles), 15);

        // Sixteen consecutive busy cycles: sticky error
        repeat (16) cycle("busy16", 0, 0, 1, 0, 0, MEMB);
        cycle("error_ignores_inputs", 1, 1, 1, 1, 0, ERR);
        cycle("error_sticky", 0, 0, 0, 1, 0, ERR);
        chk("mem_wait_frozen", 32'(mem_wait_cycles), 31);
        chk("hazard_frozen", 32'(hazard_cycles), 1);
        rst = 1'b1;
        cycle("rst_clears_error", 0, 0, 1, 0, 0, NONE);
        rst = 1'b0;
        cycle("after_error_rst", 0, 0, 0, 0, 0, NONE);
        chk("error_rst_mem_wait", 32'(mem_wait_cycles), 0);

        // Saturation on the 4-bit instance, then clear-over-increment
        repeat (20) cycle("hazard_sat", 1, 0, 0, 0, 0, HZ);
        chk("hazard_sat_cnt4", 32'(s_hazard_cycles), 15);
        chk("hazard_cnt16", 32'(hazard_cycles), 20);
        cycle("clr_with_hazard", 1, 0, 0, 0, 1, HZ);
        chk("clr_cnt4", 32'(s_hazard_cycles), 0);
        chk("clr_cnt16", 32'(hazard_cycles), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
        $finish;
    end
endmodule
